// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer family: default sizes,
// FSM state encoding and the channel-index width helper.
package stream_demux_pkg;

  localparam int DefW      = 8;
  localparam int DefLogNum = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  // Bits needed to index num channels; never narrower than one bit.
  function automatic int chan_idx_width(input int num);
    return (num <= 2) ? 1 : $clog2(num);
  endfunction

endpackage

// File: rtl/stream_demux_bit.sv
// Single-bit demultiplexer: routes d onto output line sel, all other lines 0.
module stream_demux_bit
  import stream_demux_pkg::*;
#(
  parameter int SelW = DefLogNum
) (
  input  logic                 d,
  input  logic [SelW-1:0]      sel,
  output logic [2**SelW-1:0]   y
);

  always_comb begin
    y      = '0;
    y[sel] = d;
  end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware stream demultiplexer: one input stream is steered, a whole
// packet at a time, to one of 2**LogNum output channels through a one-entry buffer.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int W      = DefW,
  parameter int LogNum = DefLogNum
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             i_data,
  input  logic                     i_valid,
  input  logic                     i_last,
  output logic                     i_ready,
  input  logic [LogNum-1:0]        s,
  output logic [(2**LogNum)*W-1:0] o_data,
  output logic [2**LogNum-1:0]     o_valid,
  output logic [2**LogNum-1:0]     o_last,
  input  logic [2**LogNum-1:0]     o_ready,
  output logic                     busy,
  output state_t                   dbg_state
);

  localparam int Num  = 2**LogNum;
  localparam int IdxW = chan_idx_width(Num);

  // Handshake: a beat moves on a port when its valid and ready are both high
  // at a rising clock edge; valid never depends on ready, and the buffered
  // beat and its destination are frozen while the downstream stalls.
  state_t              state;
  logic [LogNum-1:0]   sel;
  logic                full;
  logic [LogNum-1:0]   dest;
  logic [W-1:0]        buf_data;
  logic                buf_last;

  logic                push;
  logic [LogNum-1:0]   push_dest;

  assign i_ready   = !full || o_ready[dest];
  assign push      = i_valid && i_ready;
  assign push_dest = (state == ST_IDLE) ? s : sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= '0;
      full     <= 1'b0;
      dest     <= '0;
      buf_data <= '0;
      buf_last <= 1'b0;
    end else begin
      if (push) begin
        full     <= 1'b1;
        dest     <= push_dest;
        buf_data <= i_data;
        buf_last <= i_last;
        case (state)
          ST_IDLE: begin
            if (!i_last) begin
              state <= ST_PKT;
              sel   <= s;
            end
          end
          ST_PKT: begin
            if (i_last) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (full && o_ready[dest]) begin
        full <= 1'b0;
      end
    end
  end

  assign busy      = (state == ST_PKT) || full;
  assign dbg_state = state;

  stream_demux_bit #(.SelW(IdxW)) u_valid_demux (
    .d   (full),
    .sel (dest),
    .y   (o_valid)
  );

  // Data and last are gated by the same one-hot so idle channels read zero.
  for (genvar k = 0; k < Num; k++) begin : g_chan
    assign o_last[k]         = o_valid[k] & buf_last;
    assign o_data[k*W +: W]  = o_valid[k] ? buf_data : '0;
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed and random checks of stream_demux against a packet-level reference.
module tb_stream_demux;
  import stream_demux_pkg::*;

  localparam int W      = 8;
  localparam int LogNum = 3;
  localparam int Num    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     i_data = '0;
  logic             i_valid = 1'b0;
  logic             i_last = 1'b0;
  logic             i_ready;
  logic [LogNum-1:0] s = '0;
  logic [Num*W-1:0] o_data;
  logic [Num-1:0]   o_valid;
  logic [Num-1:0]   o_last;
  logic [Num-1:0]   o_ready = '1;
  logic             busy;
  state_t           dbg_state;

  int checks = 0;
  int failures = 0;

  // Reference: open-packet channel plus the beat currently owed downstream.
  bit             m_open;
  int             m_ch;
  bit             m_pend;
  int             m_pch;
  logic [W-1:0]   m_pdata;
  bit             m_plast;
  logic [LogNum+W:0] exp_q[$];

  stream_demux #(.W(W), .LogNum(LogNum)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_last    (i_last),
    .i_ready   (i_ready),
    .s         (s),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_last    (o_last),
    .o_ready   (o_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_ch = 0; m_pend = 0; m_pch = 0; m_pdata = '0; m_plast = 0;
    exp_q.delete();
  endtask

  task automatic compare_all();
    logic [63:0] ev, el, ed;
    logic [LogNum+W:0] e;
    ev = '0; el = '0; ed = '0;
    if (m_pend) begin
      ev[m_pch] = 1'b1;
      el[m_pch] = m_plast;
      ed = 64'(m_pdata) << (m_pch * W);
    end
    check("o_valid", 64'(o_valid), ev);
    check("o_last", 64'(o_last), el);
    check("o_data", 64'(o_data), ed);
    check("i_ready", 64'(i_ready), 64'(m_pend ? o_ready[m_pch] : 1'b1));
    check("busy", 64'(busy), 64'(m_open || m_pend));
    check("state", 64'(dbg_state), 64'(m_open ? ST_PKT : ST_IDLE));
    for (int k = 0; k < Num; k++) begin
      if (o_valid[k] && o_ready[k]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_underflow observed=ch%0d expected=no_beat", k);
        end else begin
          e = exp_q.pop_front();
          check("sb_beat", 64'({3'(k), o_data[k*W +: W], o_last[k]}), 64'(e));
        end
      end
    end
  endtask

  task automatic model_update();
    bit push, pop;
    int ch;
    if (!rst_n) return;
    pop  = m_pend && o_ready[m_pch];
    push = i_valid && (!m_pend || o_ready[m_pch]);
    if (push) begin
      ch = m_open ? m_ch : int'(s);
      exp_q.push_back({3'(ch), i_data, i_last});
      if (!m_open && !i_last) begin
        m_open = 1; m_ch = int'(s);
      end else if (m_open && i_last) begin
        m_open = 0;
      end
      m_pend = 1; m_pch = ch; m_pdata = i_data; m_plast = i_last;
    end else if (pop) begin
      m_pend = 0;
    end
  endtask

  // Check before the edge, then advance the model across it.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit v, input bit l, input logic [LogNum-1:0] sv, input logic [W-1:0] d);
    i_valid = v; i_last = l; s = sv; i_data = d;
  endtask

  initial begin
    logic [Num-1:0] ev;
    logic [LogNum-1:0] chans[4];
    chans[0] = 3'd0; chans[1] = 3'd7; chans[2] = 3'd0; chans[3] = 3'd7;

    // Reset
    model_reset();
    #1;
    compare_all();
    check("rst_valid", 64'(o_valid), 64'h0);
    repeat (2) cycle();
    rst_n = 1'b1;

    // Single-beat packet to channel 5
    drive(1, 1, 3'd5, 8'hA5);
    cycle();
    drive(0, 0, 3'd0, 8'h00);
    check("r031_valid", 64'(o_valid), 64'h20);
    check("r031_data", 64'(o_data), 64'hA5 << 40);
    check("r031_last", 64'(o_last), 64'h20);
    cycle();

    // Three-beat packet: s changes mid-packet must not redirect
    drive(1, 0, 3'd2, 8'h11);
    cycle();
    check("r032_b1", 64'(o_data), 64'h11 << 16);
    drive(1, 0, 3'd6, 8'h22);
    cycle();
    check("r032_b2_valid", 64'(o_valid), 64'h04);
    check("r032_b2", 64'(o_data), 64'h22 << 16);
    drive(1, 1, 3'd6, 8'h33);
    cycle();
    drive(0, 0, 3'd6, 8'h00);
    check("r032_b3_valid", 64'(o_valid), 64'h04);
    check("r032_b3_last", 64'(o_last), 64'h04);
    check("r032_b3", 64'(o_data), 64'h33 << 16);
    check("r032_idle", 64'(dbg_state), 64'(ST_IDLE));
    cycle();

    // Backpressure on channel 4
    o_ready = 8'hEF;
    drive(1, 1, 3'd4, 8'h4C);
    cycle();
    drive(1, 1, 3'd1, 8'h77);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("r033_hold", 64'(o_data), 64'h4C << 32);
      check("r033_valid", 64'(o_valid), 64'h10);
      check("r033_iready", 64'(i_ready), 64'h0);
      cycle();
    end
    o_ready = '1;
    #1;
    check("r033_iready_up", 64'(i_ready), 64'h1);
    cycle();
    drive(0, 0, 3'd0, 8'h00);
    check("r033_next", 64'(o_data), 64'h77 << 8);
    cycle();

    // Back-to-back single beats alternating channels 0 and 7
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, chans[i], 8'(8'h50 + i));
      #1;
      check("r034_iready", 64'(i_ready), 64'h1);
      cycle();
      ev = '0;
      ev[chans[i]] = 1'b1;
      check("r034_valid", 64'(o_valid), 64'(ev));
      check("r034_data", 64'(o_data), 64'(8'h50 + i) << (int'(chans[i]) * W));
    end
    drive(0, 0, 3'd0, 8'h00);
    cycle();

    // Reset mid-packet
    drive(1, 0, 3'd3, 8'h31);
    cycle();
    drive(1, 0, 3'd5, 8'h32);
    cycle();
    check("r035_pre", 64'(o_valid), 64'h08);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("r035_valid", 64'(o_valid), 64'h0);
    check("r035_data", 64'(o_data), 64'h0);
    check("r035_busy", 64'(busy), 64'h0);
    drive(0, 0, 3'd0, 8'h00);
    cycle();
    cycle();
    rst_n = 1'b1;
    drive(1, 1, 3'd1, 8'h99);
    cycle();
    drive(0, 0, 3'd0, 8'h00);
    check("r035_after", 64'(o_valid), 64'h02);
    check("r035_after_data", 64'(o_data), 64'h99 << 8);
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 3'($urandom), 8'($urandom));
      o_ready = 8'($urandom) | 8'($urandom);
      cycle();
    end
    drive(0, 0, 3'd0, 8'h00);
    o_ready = '1;
    repeat (3) cycle();
    check("sb_drain", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
